// File: rtl/conv2_mac_accum.sv
`default_nettype none
// ============================================================================
// Module   : conv2_mac_accum
// Purpose  : Accumulates 3 filters x 3 channels over one 5x5 conv2 window,
//            then adds bias, saturates, optionally applies ReLU and holds it.
// Revision : 1.0
// ============================================================================
module conv2_mac_accum #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int TAPS      = 25,
    parameter int RELU_EN   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic [3:1][DATA_W-1:0]   pixel_ch,
    input  logic [3:1][DATA_W-1:0]   weight_conv2_1,
    input  logic [3:1][DATA_W-1:0]   weight_conv2_2,
    input  logic [3:1][DATA_W-1:0]   weight_conv2_3,
    input  logic [3:1][DATA_W-1:0]   bias_conv2,
    output logic                     ready,
    input  logic                     out_ready,
    output logic [3:1][DATA_W-1:0]   conv2_out,
    output logic                     out_valid,
    output logic                     busy
);

    localparam int TAP_W = $clog2(TAPS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(DATA_W-1)));

    logic [1:0]                     state_q, state_d;
    logic [TAP_W-1:0]               tap_q;
    logic [3:1][ACC_W-1:0]          acc_q;
    logic [3:1][DATA_W-1:0]         out_q;
    logic                           out_valid_q;

    logic [3:1][3:1][DATA_W-1:0]    w_wt;
    logic [3:1][ACC_W-1:0]          w_mac;
    logic [3:1][DATA_W-1:0]         w_res;
    logic signed [2*DATA_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]        w_shift;
    logic signed [ACC_W:0]          w_sum;
    logic                           w_last_tap;

    assign w_wt       = {weight_conv2_3, weight_conv2_2, weight_conv2_1};
    assign w_last_tap = (tap_q == TAP_W'(TAPS));

    // Per-filter sum of the three channel products for the current tap
    always_comb begin
        w_mac  = '0;
        w_prod = '0;
        for (int f = 1; f <= 3; f++) begin
            for (int c = 1; c <= 3; c++) begin
                w_prod   = (2*DATA_W)'($signed(w_wt[f][c])) *
                           (2*DATA_W)'($signed(pixel_ch[c]));
                w_mac[f] = w_mac[f] + ACC_W'(w_prod);
            end
        end
    end

    // Rescale to the output format, add bias, clamp, optional ReLU
    always_comb begin
        w_res   = '0;
        w_shift = '0;
        w_sum   = '0;
        for (int f = 1; f <= 3; f++) begin
            w_shift = $signed(acc_q[f]) >>> FRAC_BITS;
            w_sum   = (ACC_W+1)'(w_shift) + (ACC_W+1)'($signed(bias_conv2[f]));
            if (w_sum > SAT_MAX) begin
                w_sum = SAT_MAX;
            end else if (w_sum < SAT_MIN) begin
                w_sum = SAT_MIN;
            end
            if ((RELU_EN != 0) && (w_sum < 0)) begin
                w_sum = '0;
            end
            w_res[f] = w_sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (ready && w_last_tap) state_d = S_FINAL;
            S_FINAL: state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ready looks only at control inputs, never at the weights
    always_comb begin
        ready = (state_q == S_ACCUM) && start && pix_valid;
        busy  = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q       <= TAP_W'(1);
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tap_q <= TAP_W'(1);
                        acc_q <= '0;
                    end
                end
                S_ACCUM: begin
                    if (ready) begin
                        for (int f = 1; f <= 3; f++) begin
                            acc_q[f] <= acc_q[f] + w_mac[f];
                        end
                        tap_q <= w_last_tap ? TAP_W'(1) : tap_q + TAP_W'(1);
                    end
                end
                S_FINAL: begin
                    out_q       <= w_res;
                    out_valid_q <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign conv2_out = out_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2_mac_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2_mac_accum
// Purpose  : Directed + randomized checks of conv2_mac_accum (ReLU and linear
//            instances) against an arithmetic window model.
// Revision : 1.0
// ============================================================================
module tb_conv2_mac_accum;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                pix_valid;
    logic [3:1][15:0]    pixel_ch;
    logic [3:1][15:0]    weight_conv2_1;
    logic [3:1][15:0]    weight_conv2_2;
    logic [3:1][15:0]    weight_conv2_3;
    logic [3:1][15:0]    bias_conv2;
    logic                out_ready;
    logic                ready, out_valid, busy;
    logic [3:1][15:0]    conv2_out;
    logic                ready_lin, out_valid_lin, busy_lin;
    logic [3:1][15:0]    conv2_out_lin;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv2_mac_accum #(.RELU_EN(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pixel_ch(pixel_ch), .weight_conv2_1(weight_conv2_1),
        .weight_conv2_2(weight_conv2_2), .weight_conv2_3(weight_conv2_3),
        .bias_conv2(bias_conv2), .ready(ready), .out_ready(out_ready),
        .conv2_out(conv2_out), .out_valid(out_valid), .busy(busy)
    );

    conv2_mac_accum #(.RELU_EN(0)) u_dut_lin (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pixel_ch(pixel_ch), .weight_conv2_1(weight_conv2_1),
        .weight_conv2_2(weight_conv2_2), .weight_conv2_3(weight_conv2_3),
        .bias_conv2(bias_conv2), .ready(ready_lin), .out_ready(out_ready),
        .conv2_out(conv2_out_lin), .out_valid(out_valid_lin), .busy(busy_lin)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input longint acc, input logic [15:0] b, input bit relu);
        longint r;
        r = (acc >>> 8) + longint'($signed(b));
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    function automatic logic [15:0] gen_val(input int mode, input logic [15:0] fix);
        if (mode == 1) return 16'($urandom_range(0, 4095)) - 16'd2048;
        if (mode == 2) return 16'($urandom);
        return fix;
    endfunction

    // mode: 0 fixed, 1 small random, 2 full-range random
    // gapmode: 1 toggles pix_valid and drops start for 3 cycles mid-window
    // abort_at: >0 asserts reset after that many accepted taps
    task automatic run_window(input string tag, input int mode, input logic [15:0] wfix,
                              input logic [15:0] pfix, input int gapmode,
                              input int abort_at, input int hold_cycles);
        longint      acc [3];
        logic [15:0] w [3][3];
        logic [15:0] p [3];
        logic [15:0] e_relu [3];
        logic [15:0] e_lin [3];
        int          n_acc = 0;
        int          cyc   = 0;
        int          drop  = 0;
        bit          tgl   = 1'b0;
        bit          new_tap = 1'b1;

        for (int f = 0; f < 3; f++) acc[f] = 0;
        start = 1'b1;
        pix_valid = 1'b1;
        while (n_acc < 25 && cyc < 400) begin
            if (abort_at > 0 && n_acc == abort_at) break;
            if (new_tap) begin
                for (int c = 0; c < 3; c++) begin
                    p[c] = gen_val(mode, pfix);
                    for (int f = 0; f < 3; f++) w[f][c] = gen_val(mode, wfix);
                    pixel_ch[c+1]       = p[c];
                    weight_conv2_1[c+1] = w[0][c];
                    weight_conv2_2[c+1] = w[1][c];
                    weight_conv2_3[c+1] = w[2][c];
                end
                new_tap = 1'b0;
            end
            if (gapmode == 1) begin
                pix_valid = tgl;
                tgl = ~tgl;
                if (n_acc == 12 && drop < 3) begin
                    start = 1'b0;
                    drop++;
                end else begin
                    start = 1'b1;
                end
            end
            #1;
            if (ready) begin
                for (int f = 0; f < 3; f++)
                    for (int c = 0; c < 3; c++)
                        acc[f] += longint'($signed(w[f][c])) * longint'($signed(p[c]));
                n_acc++;
                new_tap = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end

        if (abort_at > 0) begin
            check({tag, " taps_before_reset"}, n_acc, abort_at);
            reset = 1'b1;
            @(negedge clk);
            check({tag, " rst_out_valid"}, out_valid, 1'b0);
            check({tag, " rst_conv2_out"}, conv2_out, 48'h0);
            check({tag, " rst_ready"}, ready, 1'b0);
            check({tag, " rst_busy"}, busy, 1'b0);
            reset = 1'b0;
            start = 1'b0;
            @(negedge clk);
            return;
        end

        check({tag, " taps"}, n_acc, 25);
        start = 1'b0;
        pix_valid = 1'b0;
        for (int f = 0; f < 3; f++) begin
            e_relu[f] = ref_out(acc[f], bias_conv2[f+1], 1'b1);
            e_lin[f]  = ref_out(acc[f], bias_conv2[f+1], 1'b0);
        end
        check({tag, " final_out_valid"}, out_valid, 1'b0);
        check({tag, " final_ready"}, ready, 1'b0);
        check({tag, " final_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " out_relu"}, conv2_out, {e_relu[2], e_relu[1], e_relu[0]});
        check({tag, " out_lin"}, conv2_out_lin, {e_lin[2], e_lin[1], e_lin[0]});
        start = 1'b1;
        pix_valid = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, out_valid, 1'b1);
            check({tag, " hold_out"}, conv2_out, {e_relu[2], e_relu[1], e_relu[0]});
            check({tag, " hold_ready"}, ready, 1'b0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " ret_valid"}, out_valid, 1'b0);
        check({tag, " ret_busy"}, busy, 1'b0);
        check({tag, " ret_out_kept"}, conv2_out, {e_relu[2], e_relu[1], e_relu[0]});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        out_ready = 1'b0;
        pixel_ch = '0;
        weight_conv2_1 = '0;
        weight_conv2_2 = '0;
        weight_conv2_3 = '0;
        bias_conv2 = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset ready", ready, 1'b0);
        check("reset conv2_out", conv2_out, 48'h0);
        reset = 1'b0;
        start = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk);
        check("accum busy", busy, 1'b1);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_window("unit", 0, 16'd256, 16'd256, 0, 0, 0);
        check("unit value", conv2_out, {16'd19200, 16'd19200, 16'd19200});
        bias_conv2 = {16'd0, 16'hFF80, 16'd128};
        run_window("bias", 0, 16'd256, 16'd256, 0, 0, 0);
        check("bias value", conv2_out, {16'd19200, 16'd19072, 16'd19328});
        bias_conv2 = '0;
        run_window("sat", 0, 16'd32512, 16'd32512, 0, 0, 0);
        check("sat value", conv2_out, {16'd32767, 16'd32767, 16'd32767});
        run_window("neg", 0, 16'hFF00, 16'd256, 0, 0, 0);
        check("neg relu value", conv2_out, 48'h0);
        check("neg lin value", conv2_out_lin, {3{16'hB500}});
        run_window("gaps", 0, 16'd256, 16'd256, 1, 0, 0);
        check("gaps value", conv2_out, {16'd19200, 16'd19200, 16'd19200});
        run_window("abort", 0, 16'd256, 16'd256, 0, 10, 0);
        run_window("fresh", 0, 16'd256, 16'd256, 0, 0, 5);
        check("fresh value", conv2_out, {16'd19200, 16'd19200, 16'd19200});
        for (int k = 0; k < 4; k++) begin
            bias_conv2 = {16'($urandom_range(0, 511)) - 16'd256,
                          16'($urandom_range(0, 511)) - 16'd256,
                          16'($urandom_range(0, 511)) - 16'd256};
            run_window("rand_small", 1, 16'd0, 16'd0, k % 2, 0, k);
        end
        bias_conv2 = 48'($urandom) ^ {16'($urandom), 32'd0};
        run_window("rand_full", 2, 16'd0, 16'd0, 1, 0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
